// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory: port 0 fetches, port 1 loads/stores.
// Define ARB_FIXED_PRIO_EN to make port 1 win every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              gnt_q, gnt_d;
    logic              is_write_q, is_write_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              winner;

`ifdef ARB_FIXED_PRIO_EN
    assign winner = p1_req;
`else
    logic last_gnt_q, last_gnt_d;

    // A tie goes to the port that did not win last time.
    assign winner = (p0_req && p1_req) ? ~last_gnt_q : p1_req;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        gnt_d       = gnt_q;
        is_write_d  = is_write_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d   = ST_ACCESS;
                    gnt_d     = winner;
                    lat_cnt_d = LAT_INIT;
`ifndef ARB_FIXED_PRIO_EN
                    last_gnt_d = winner;
`endif
                    if (winner) begin
                        mem_addr_d  = p1_addr;
                        mem_wdata_d = p1_wdata;
                        mem_we_d    = p1_we;
                        is_write_d  = p1_we;
                    end else begin
                        mem_addr_d  = p0_addr;
                        mem_wdata_d = '0;
                        mem_we_d    = 1'b0;
                        is_write_d  = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                // The write strobe lasts only the first access cycle; the address stays put.
                mem_we_d = 1'b0;
                if (lat_cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                    if (!is_write_q) begin
                        if (gnt_q) p1_rdata_d = mem_rdata;
                        else       p0_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register, including the write strobe, clears asynchronously so an aborted store stops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 3'd0;
            gnt_q       <= 1'b0;
            is_write_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_gnt_q  <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the same pre-edge values.
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            gnt_q       <= gnt_d;
            is_write_q  <= is_write_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
`ifndef ARB_FIXED_PRIO_EN
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = gnt_q;
    assign p0_ack    = (state_q == ST_DONE) && !gnt_q;
    assign p1_ack    = (state_q == ST_DONE) && gnt_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks and read data are queued in grant order.
// Handles both the round-robin build and the ARB_FIXED_PRIO_EN build.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req, p1_we;
    logic [63:0] p0_addr, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack, mem_we, busy, gnt_id;
    logic [63:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    // Memory model: data appears LAT cycles after the address is presented.
    logic [63:0] mem [256];
    logic [63:0] rd_pipe [8];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr;
    logic [63:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always_comb begin
        if (LAT == 1) mem_rdata = mem[mem_addr[7:0]];
        else          mem_rdata = rd_pipe[(LAT >= 2) ? LAT - 2 : 0];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int idle_cnt = 0;
    int c0, c1, cyc0, i0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (reset && !busy) idle_cnt++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic        port;
        logic [63:0] rd0;
        logic [63:0] rd1;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] ref_mem [256];
    logic [63:0] m_rd0 = '0;
    logic [63:0] m_rd1 = '0;

    // Must be called in the order the arbiter is expected to grant.
    function automatic void push_exp(input logic port, input logic we, input logic [7:0] a,
                                     input logic [63:0] wd);
        exp_t e;
        if (!port)   m_rd0 = ref_mem[a];
        else if (we) ref_mem[a] = wd;
        else         m_rd1 = ref_mem[a];
        e.port = port;
        e.rd0  = m_rd0;
        e.rd1  = m_rd1;
        exp_q.push_back(e);
    endfunction

    exp_t got_e;
    always @(negedge clk) begin
        if (reset && (p0_ack || p1_ack)) begin
            check("ack_both", 64'(p0_ack & p1_ack), 64'd0);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 64'(p1_ack), 64'(2));
            end else begin
                got_e = exp_q.pop_front();
                check("ack_port", 64'(p1_ack), 64'(got_e.port));
                check("p0_rdata", p0_rdata, got_e.rd0);
                check("p1_rdata", p1_rdata, got_e.rd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        step();
        ld_en = 1'b0;
    endtask

    // One isolated request issued in an IDLE cycle; checks latency, grant and write strobe count.
    task automatic run_req(input logic port, input logic we, input logic [7:0] a, input logic [63:0] wd);
        int   n = 0;
        int   we_cnt = 0;
        logic seen = 1'b0;
        push_exp(port, we, a, wd);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = 64'(a); p1_wdata = wd;
        end else begin
            p0_req = 1'b1; p0_addr = 64'(a);
        end
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_we) we_cnt++;
            if (n == 1) check("idle_busy", 64'(busy), 64'd0);
            if (n == 2) check("gnt_id", 64'(gnt_id), 64'(port));
            seen = port ? p1_ack : p0_ack;
        end
        check("ack_latency", 64'(n), 64'(LAT + 2));
        check("we_count", 64'(we_cnt), 64'(port && we));
        p0_req = 1'b0;
        p1_req = 1'b0;
        step();
    endtask

    // A requester that issues cnt loads, re-requesting in the cycle after each ack.
    task automatic port_loop(input logic port, input logic [7:0] a0, input logic [7:0] a1,
                             input int cnt, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < cnt; i++) begin
            int   n = 0;
            logic seen = 1'b0;
            if (port) begin
                p1_req = 1'b1; p1_we = 1'b0; p1_addr = 64'((i == 0) ? a0 : a1);
            end else begin
                p0_req = 1'b1; p0_addr = 64'((i == 0) ? a0 : a1);
            end
            while (!seen && n < 100) begin
                @(negedge clk);
                n++;
                seen = port ? p1_ack : p0_ack;
            end
            if (!seen) check("port_timeout", 64'd0, 64'd1);
            last_cyc = cyc;
            if (port) p1_req = 1'b0;
            else      p0_req = 1'b0;
            step();
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
        p0_addr = '0; p1_addr = '0; p1_wdata = '0;

        preload(8'h10, 64'h0000_0000_00A0_0513);
        preload(8'h18, 64'h1111_2222_3333_4444);
        preload(8'h80, 64'h5555_6666_7777_8888);
        preload(8'h88, 64'h9999_AAAA_BBBB_CCCC);
        preload(8'h40, 64'h0123_4567_89AB_CDEF);
        preload(8'h00, 64'h0000_0000_0000_0013);

        @(negedge clk);
        check("rst_p0_ack", 64'(p0_ack), 64'd0);
        check("rst_p1_ack", 64'(p1_ack), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gnt_id", 64'(gnt_id), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_p0_rdata", p0_rdata, 64'd0);
        check("rst_p1_rdata", p1_rdata, 64'd0);
        reset = 1'b1;
        step();

        // Both ports requesting from reset.
`ifdef ARB_FIXED_PRIO_EN
        push_exp(1'b1, 1'b0, 8'h80, '0);
        push_exp(1'b1, 1'b0, 8'h88, '0);
        push_exp(1'b0, 1'b0, 8'h10, '0);
        push_exp(1'b0, 1'b0, 8'h18, '0);
`else
        push_exp(1'b0, 1'b0, 8'h10, '0);
        push_exp(1'b1, 1'b0, 8'h80, '0);
        push_exp(1'b0, 1'b0, 8'h18, '0);
        push_exp(1'b1, 1'b0, 8'h88, '0);
`endif
        cyc0 = cyc;
        i0   = idle_cnt;
        fork
            port_loop(1'b0, 8'h10, 8'h18, 2, c0);
            port_loop(1'b1, 8'h80, 8'h88, 2, c1);
        join
        check("tie_cycles", 64'(((c0 > c1) ? c0 : c1) - cyc0 + 1), 64'(4 * (LAT + 2)));
        check("tie_idle_cycles", 64'(idle_cnt - i0), 64'd4);

        // Single fetch, store, then load back.
        run_req(1'b0, 1'b0, 8'h10, '0);
        run_req(1'b1, 1'b1, 8'h80, 64'hDEAD_BEEF_0000_0042);
        run_req(1'b1, 1'b0, 8'h80, '0);

        // Port 1 requests while a port 0 fetch is in flight.
        push_exp(1'b0, 1'b0, 8'h10, '0);
        push_exp(1'b1, 1'b0, 8'h18, '0);
        p0_req = 1'b1; p0_addr = 64'h10;
        step();
        step();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 64'h18;
        n = 0;
        do begin @(negedge clk); n++; end while (!p0_ack && n < 20);
        check("busy_p0_ack", 64'(p0_ack), 64'd1);
        p0_req = 1'b0;
        @(negedge clk);
        check("busy_gap_idle", 64'(busy), 64'd0);
        check("busy_gap_gnt", 64'(gnt_id), 64'd0);
        @(negedge clk);
        check("busy_p1_gnt", 64'(gnt_id), 64'd1);
        n = 0;
        while (!p1_ack && n < 20) begin @(negedge clk); n++; end
        check("busy_p1_ack", 64'(p1_ack), 64'd1);
        p1_req = 1'b0;
        step();

        // Reset during the first access cycle of a store; no ack may follow.
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 64'h60; p1_wdata = 64'hCAFE_F00D_1234_5678;
        step();
        check("mid_we_before", 64'(mem_we), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_we", 64'(mem_we), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_p1_ack", 64'(p1_ack), 64'd0);
        check("mid_gnt", 64'(gnt_id), 64'd0);
        p1_req = 1'b0; p1_we = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        check("mid_idle_after", 64'(busy), 64'd0);
`ifdef ARB_FIXED_PRIO_EN
        push_exp(1'b1, 1'b0, 8'h88, '0);
        push_exp(1'b0, 1'b0, 8'h18, '0);
`else
        push_exp(1'b0, 1'b0, 8'h18, '0);
        push_exp(1'b1, 1'b0, 8'h88, '0);
`endif
        fork
            port_loop(1'b0, 8'h18, 8'h18, 1, c0);
            port_loop(1'b1, 8'h88, 8'h88, 1, c1);
        join

        // Alternating back-to-back traffic with stores mixed in.
        for (int i = 0; i < 8; i++) begin
            run_req(1'(i % 2), (i % 4) == 1, 8'h40, {$urandom, $urandom});
        end
        run_req(1'b0, 1'b0, 8'h00, '0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 64-bit data memory between two requesters in the multicycle core.
  - Port 0 is the instruction-fetch path, read-only.
  - Port 1 is the load/store path, read/write.
- Sits between control_top/processor and the on-chip memory.
- Serialises accesses with a fixed access latency and a req/ack handshake.
- Arbitrates round-robin when both ports request in the same cycle.

Parameters:
- MEM_LAT, 2: memory access latency in cycles. Legal range 1..8.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- p0_req  in  1  fetch request; held until p0_ack
- p0_addr  in  ADDR_W  fetch address
- p0_ack  out  1  one-cycle completion pulse for port 0
- p0_rdata  out  DATA_W  port 0 read data, registered
- p1_req  in  1  load/store request; held until p1_ack
- p1_we  in  1  1 = store, 0 = load
- p1_addr  in  ADDR_W  load/store address
- p1_wdata  in  DATA_W  store data
- p1_ack  out  1  one-cycle completion pulse for port 1
- p1_rdata  out  DATA_W  port 1 read data, registered
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after address
- busy  out  1  high whenever the FSM is not IDLE
- gnt_id  out  1  port currently owning the memory; 0 when IDLE

Behaviour:
- Reset values (reset=0, asynchronous):
  - state=IDLE; all outputs 0, including p*_ack, mem_we, busy, gnt_id, mem_addr, mem_wdata, p0_rdata, p1_rdata.
  - last_gnt=1, so port 0 wins the first tie.
  - lat_cnt=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req → stay IDLE.
  - Exactly one req → grant that port.
  - Both reqs → grant the port != last_gnt.
  - On grant:
    - Register addr, wdata and we of the winner into mem_addr/mem_wdata/mem_we.
    - Set gnt_id; last_gnt<=winner; lat_cnt<=MEM_LAT-1.
    - Go to ACCESS.
  - Port 0 grants always drive mem_we=0.
- ACCESS:
  - mem_we high only during the first ACCESS cycle; forced to 0 afterwards.
  - mem_addr/mem_wdata held stable for the whole ACCESS period.
  - lat_cnt decrements each cycle. At lat_cnt==0:
    - Capture mem_rdata into the granted port's p*_rdata (loads and fetches only; stores leave p1_rdata unchanged).
    - Go to DONE.
- DONE:
  - The granted port's p*_ack is high for exactly this one cycle.
  - Next state is always IDLE.
  - gnt_id returns to 0 in IDLE.
- Latency:
  - req sampled at edge k → ACCESS from cycle k+1.
  - ack high in cycle k+1+MEM_LAT.
  - Total service time is MEM_LAT+2 cycles including the IDLE cycle.
- Requester rule:
  - req must be deasserted by the edge that ends its ack cycle.
  - A req seen in IDLE is always a new request.
  - The arbiter does not suppress back-to-back requests from the same port when the other port is idle.
- Requests arriving while busy:
  - Ignored until IDLE; never lost while the requester holds req.
  - Inputs of a non-granted port are never sampled.
- Stability:
  - p*_rdata holds its value until that port's next read completes.
  - p*_rdata is never glitched by the other port's accesses.
- MEM_LAT=1: ACCESS lasts one cycle; mem_we and the rdata capture happen in the same ACCESS cycle.
- Reset mid-operation:
  - Immediate return to IDLE; mem_we drops asynchronously.
  - An in-flight store may or may not have been written.
  - No ack is issued for the aborted access.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- When defined:
  - Port 1 (load/store) always wins ties.
  - last_gnt is neither used nor required.
  - Port 0 can starve while port 1 requests continuously.
- When undefined: round-robin as specified above.

Test Plan:
- Single fetch, MEM_LAT=2, memory word 0x0000_0000_00A0_0513 at addr 0x10:
  - p0_req=1, p0_addr=0x10.
  - p0_ack pulses 3 cycles after the sample edge; p0_rdata=0x00A0_0513; mem_we never high.
- Store then load, port 1:
  - Store 0xDEAD_BEEF_0000_0042 to 0x80: mem_we high exactly 1 cycle; p1_ack pulses; p1_rdata unchanged.
  - Following load from 0x80 → p1_rdata=0xDEAD_BEEF_0000_0042.
- Simultaneous requests from reset:
  - p0 and p1 both requesting → grant order p0, p1, p0, p1 across 4 accesses; each ack is 1 cycle; busy stays low only in IDLE cycles between accesses.
  - With ARB_FIXED_PRIO_EN defined: p1 is granted first and repeatedly while it keeps requesting.
- Request while busy:
  - p1_req rises in the 2nd ACCESS cycle of a p0 fetch.
  - p1 is granted in the IDLE cycle after p0's DONE; p0_rdata is unchanged by p1's load.
- Reset mid-access:
  - reset=0 during a p1 store's first ACCESS cycle → mem_we, busy, p1_ack go 0 immediately; FSM is IDLE after release.
  - p0_req with reset=1 → served normally (p0 wins; last_gnt reset to 1).
- MEM_LAT=1 build:
  - Fetch from addr 0x0 → p0_ack exactly 2 cycles after the sample edge.
  - Back-to-back alternating requests → no lost or duplicated acks over 8 accesses.
